// File: rtl/button_led_mode_ctrl.sv
// button_led_mode_ctrl: debounce a raw push button, classify presses as short/long, and step the LED through OFF/ON/SLOW/FAST.
//
// Ports:
//   clk          system clock, the only clock in the block
//   rst          synchronous reset, active-high
//   push_button  raw button, active-high, asynchronous and bouncing
//   led          LED drive, active-high, registered
//   mode         current mode: 0=OFF, 1=ON, 2=SLOW, 3=FAST
//   press_pulse  one-cycle strobe on each debounced rising edge
//
// All four parameters must be >= 2.
module button_led_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 10000000,
    parameter int SLOW_HALF       = 5000000,
    parameter int FAST_HALF       = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_button,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_pulse
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int HW   = $clog2(LONG_CYCLES + 1);
    localparam int BMAX = SLOW_HALF > FAST_HALF ? SLOW_HALF : FAST_HALF;
    localparam int BW   = $clog2(BMAX);

    typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_SLOW = 2'd2, M_FAST = 2'd3} mode_e;

    logic          s1_q, s2_q, db_q, db_prev_q, press_q, led_q, phase_q, long_fired_q;
    logic [DW-1:0] dcnt_q;
    logic [HW-1:0] hcnt_q;
    logic [BW-1:0] bcnt_q;
    mode_e         mode_q, mode_d;
    logic          rise, fall, long_hit, blinking;
    logic [1:0]    mode_inc;
    logic [BW-1:0] half_m1;

    always_comb begin
        rise     = db_q & ~db_prev_q;
        fall     = ~db_q & db_prev_q;
        // The hold counter is cleared by fall, so a long event can never coincide with a fall.
        long_hit = db_q & ~long_fired_q & (hcnt_q == HW'(LONG_CYCLES - 1));
        mode_inc = mode_q + 2'd1;
        mode_d   = long_hit ? M_OFF : (fall & ~long_fired_q) ? mode_e'(mode_inc) : mode_q;
        blinking = (mode_q == M_SLOW) || (mode_q == M_FAST);
        half_m1  = (mode_q == M_FAST) ? BW'(FAST_HALF - 1) : BW'(SLOW_HALF - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            db_q         <= 1'b0;
            db_prev_q    <= 1'b0;
            dcnt_q       <= '0;
            hcnt_q       <= '0;
            bcnt_q       <= '0;
            long_fired_q <= 1'b0;
            mode_q       <= M_OFF;
            phase_q      <= 1'b1;
            led_q        <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            s1_q <= push_button;
            s2_q <= s1_q;
            // Any return to the debounced level restarts the qualification window.
            if (s2_q == db_q) begin
                dcnt_q <= '0;
            end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_q   <= s2_q;
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_q + 1'b1;
            end
            db_prev_q <= db_q;
            press_q   <= rise;
            if (fall) begin
                hcnt_q       <= '0;
                long_fired_q <= 1'b0;
            end else begin
                if (db_q && hcnt_q != HW'(LONG_CYCLES))
                    hcnt_q <= hcnt_q + 1'b1;
                if (long_hit)
                    long_fired_q <= 1'b1;
            end
            mode_q <= mode_d;
            // A mode change restarts the blink so a new blink mode always opens with a full high half.
            if (mode_d != mode_q) begin
                bcnt_q  <= '0;
                phase_q <= 1'b1;
            end else if (!blinking) begin
                bcnt_q <= '0;
            end else if (bcnt_q == half_m1) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
            led_q <= (mode_q == M_OFF) ? 1'b0 : (mode_q == M_ON) ? 1'b1 : phase_q;
        end
    end

    assign led         = led_q;
    assign mode        = mode_q;
    assign press_pulse = press_q;
endmodule

// File: doc/button_led_mode_ctrl.md
Name: button_led_mode_ctrl

Overview:
Controller that sequences the board LED from a single raw push button.
- Synchronises and debounces the button.
- Classifies each debounced press as short or long.
- Steps the LED through four modes: OFF, ON, SLOW blink, FAST blink.
- Sits between the board button pin and the LED pin, and replaces the direct button-to-LED connection in the top level.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive cycles the synchronised input must differ from the debounced level before it is accepted (10 ms at 10 MHz)
LONG_CYCLES, 10000000, debounced-high hold length that counts as a long press (1 s at 10 MHz)
SLOW_HALF, 5000000, LED half-period in SLOW mode, in clk cycles
FAST_HALF, 1000000, LED half-period in FAST mode, in clk cycles

Ports:
clk  input  1  system clock; only clock in the block
rst  input  1  synchronous reset, active-high
push_button  input  1  raw button, active-high, asynchronous to clk, bouncing
led  output  1  LED drive, active-high, registered
mode  output  2  current mode: 0=OFF, 1=ON, 2=SLOW, 3=FAST
press_pulse  output  1  one-cycle strobe on each debounced rising edge

Behaviour:
Clock and reset
- One clock; reset is synchronous and active-high.
- All state updates on the rising edge of clk.
- While rst=1 at an edge, every register clears: sync FFs=0, db=0, all counters=0, long_fired=0, mode=0, phase=1, led=0, press_pulse=0.
- Reset mid-press or mid-blink discards all history. After rst falls, a button still held must be re-debounced and produces a fresh press_pulse.

Synchroniser
- Two FFs: s1<=push_button, s2<=s1.

Debouncer
- Counter dcnt, width clog2(DEBOUNCE_CYCLES).
- If s2==db: dcnt<=0.
- Else if dcnt==DEBOUNCE_CYCLES-1: db<=s2, dcnt<=0.
- Else dcnt<=dcnt+1.
- A bounce shorter than DEBOUNCE_CYCLES restarts the count and never changes db.
- Latency: db changes DEBOUNCE_CYCLES+2 edges after a clean push_button transition.

Edge detect
- db_d<=db.
- rise = db & ~db_d; fall = ~db & db_d.
- press_pulse is registered: press_pulse<=rise, so it is high exactly one cycle, one edge after db rises.

Hold counter
- hcnt counts while db=1 and saturates at LONG_CYCLES.
- On the edge where hcnt reaches LONG_CYCLES-1 with db=1 and long_fired=0: long_fired<=1 and mode<=OFF.
- hcnt and long_fired clear on fall.
- A held button never fires a second long event.

Mode FSM (OFF -> ON -> SLOW -> FAST -> OFF)
- On fall with long_fired=0 (short press): mode<=mode+1, wrapping 3->0.
- On fall with long_fired=1: mode unchanged (already OFF).
- Long-press action takes priority; fall and the long event cannot coincide because fall clears the counter.

Blink generator
- Counter bcnt, width clog2(SLOW_HALF).
- On any mode change: bcnt<=0, phase<=1.
- In SLOW/FAST: when bcnt==HALF-1, toggle phase and set bcnt<=0; otherwise increment. HALF is the half-period of the current mode.
- In OFF/ON: bcnt held at 0.

LED output
- Registered: led<=0 (OFF), 1 (ON), phase (SLOW/FAST).
- led lags the mode register by one edge.
- On entry to SLOW/FAST, led=1 for exactly HALF cycles, then toggles every HALF cycles.

Width rules
- All counters compare with ==; no overflow is reachable.
- Parameters must be >=2; parameters below 2 are illegal configuration.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_CYCLES=40, SLOW_HALF=8, FAST_HALF=2.
1. Reset: assert rst 3 cycles with push_button=1 -> led=0, mode=0, press_pulse=0 throughout. After release, press_pulse fires once, 7 edges after rst deasserts (2 sync + 4 debounce + 1).
2. Bounce rejection: push_button toggles 1,0,1,0 with 2-cycle pulses, then stays 0 -> db, press_pulse, mode never change.
3. Short-press cycling: four clean presses, each 10 cycles high and 20 low -> mode goes 1,2,3,0. Each step occurs 1 edge after db falls; led follows 1 edge later.
4. Blink timing: enter SLOW -> led high 8 cycles, low 8, high 8. Enter FAST -> period 4 cycles starting high. Check the exact toggle edges.
5. Long press from FAST: hold 60 cycles -> mode=0 on the edge hcnt hits 39 while still held. No further change while held; on release mode stays 0 with no advance.
6. Reset mid-blink: in SLOW at bcnt=5, pulse rst 1 cycle -> next cycle mode=0, led=0, bcnt=0. The next short press yields mode=1.
